ex_wb_skid: RTL and testbench

//  Execute-to-writeback pipeline register for the shift/ALU result path. Captures the

---
 rtl/ex_wb_skid_if.sv | 31 +++
 rtl/ex_wb_skid.sv | 107 ++++++++++
 tb/tb_ex_wb_skid.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ex_wb_skid_if.sv
// Handshake, writeback and forwarding bundle between execute, the EX/WB skid buffer and writeback/decode.
interface ex_wb_skid_if #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
);
    logic             flush;
    logic             ex_valid;
    logic             ex_ready;
    logic [XLEN-1:0]  ex_result;
    logic [RF_AW-1:0] ex_rd;
    logic             ex_we;
    logic             wb_valid;
    logic             wb_ready;
    logic [XLEN-1:0]  wb_result;
    logic [RF_AW-1:0] wb_rd;
    logic             wb_we;
    logic [RF_AW-1:0] fwd_rs;
    logic             fwd_hit;
    logic [XLEN-1:0]  fwd_data;
    logic [1:0]       occ;

    modport slave (
        input  flush, ex_valid, ex_result, ex_rd, ex_we, wb_ready, fwd_rs,
        output ex_ready, wb_valid, wb_result, wb_rd, wb_we, fwd_hit, fwd_data, occ
    );

    modport master (
        output flush, ex_valid, ex_result, ex_rd, ex_we, wb_ready, fwd_rs,
        input  ex_ready, wb_valid, wb_result, wb_rd, wb_we, fwd_hit, fwd_data, occ
    );
endinterface

// File: rtl/ex_wb_skid.sv
// Two-entry EX->WB skid buffer; ex_ready depends only on registered occupancy, plus decode bypass lookup.
//
// state | meaning
// EMPTY | no entries, wb_valid=0
// ONE   | one entry at head
// FULL  | two entries, ex_ready=0
module ex_wb_skid #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic         clk,
    input  logic         rst,
    ex_wb_skid_if.slave  bus_io
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [XLEN-1:0]  res_q [2];
    logic [RF_AW-1:0] rd_q  [2];
    logic [1:0]       we_q;

    logic             ex_ready_w;
    logic             wb_valid_w;
    logic             push;
    logic             pop;
    logic             store_we;
    logic             young;
    logic             match_head;
    logic             match_young;
    logic             fwd_hit_w;

    assign ex_ready_w = (state_q != FULL);
    assign wb_valid_w = (state_q != EMPTY);
    assign push       = bus_io.ex_valid & ex_ready_w;
    assign pop        = wb_valid_w & bus_io.wb_ready;
    assign store_we   = bus_io.ex_we & (bus_io.ex_rd != '0);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) tail_d = ~tail_q;
        if (pop)  head_d = ~head_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        // Flush wins over everything; a pop this cycle was already presented to writeback.
        if (bus_io.flush) begin
            state_d = EMPTY;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i] <= '0;
                rd_q[i]  <= '0;
            end
            we_q <= '0;
        end else if (push && !bus_io.flush) begin
            res_q[tail_q] <= bus_io.ex_result;
            rd_q[tail_q]  <= bus_io.ex_rd;
            we_q[tail_q]  <= store_we;
        end
    end

    assign bus_io.ex_ready  = ex_ready_w;
    assign bus_io.wb_valid  = wb_valid_w;
    assign bus_io.wb_result = wb_valid_w ? res_q[head_q] : '0;
    assign bus_io.wb_rd     = wb_valid_w ? rd_q[head_q]  : '0;
    assign bus_io.wb_we     = wb_valid_w & we_q[head_q];
    assign bus_io.occ       = state_q;

    // The younger entry only exists when full; it shadows the head on an rd match.
    assign young       = ~head_q;
    assign match_head  = wb_valid_w & we_q[head_q] & (rd_q[head_q] == bus_io.fwd_rs);
    assign match_young = (state_q == FULL) & we_q[young] & (rd_q[young] == bus_io.fwd_rs);
    assign fwd_hit_w   = (bus_io.fwd_rs != '0) & (match_head | match_young);

    assign bus_io.fwd_hit  = fwd_hit_w;
    assign bus_io.fwd_data = !fwd_hit_w  ? '0 :
                             match_young ? res_q[young] : res_q[head_q];
endmodule

// File: tb/tb_ex_wb_skid.sv
// Directed vector table plus async-reset sequence and a random run against a queue model of the skid buffer.
module tb_ex_wb_skid;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_wb_skid_if #(.XLEN(32), .RF_AW(5)) bus ();

    ex_wb_skid #(.XLEN(32), .RF_AW(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ex_valid;
        logic [31:0] ex_result;
        logic [4:0]  ex_rd;
        logic        ex_we;
        logic        wb_ready;
        logic        flush;
        logic [4:0]  fwd_rs;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_we;
        logic        e_hit;
        logic [31:0] e_fd;
        logic [1:0]  e_occ;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    vec_t vecs[$];
    ent_t model_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input string nm, input logic v, input logic [31:0] r, input logic [4:0] rd,
                       input logic we, input logic wr, input logic fl, input logic [4:0] fr,
                       input logic er, input logic wv, input logic [31:0] wres, input logic [4:0] wrd,
                       input logic wwe, input logic hit, input logic [31:0] fd, input logic [1:0] oc);
        vec_t t;
        t.name = nm; t.ex_valid = v; t.ex_result = r; t.ex_rd = rd; t.ex_we = we;
        t.wb_ready = wr; t.flush = fl; t.fwd_rs = fr;
        t.e_ready = er; t.e_valid = wv; t.e_res = wres; t.e_rd = wrd; t.e_we = wwe;
        t.e_hit = hit; t.e_fd = fd; t.e_occ = oc;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd, input logic we,
                         input logic wr, input logic fl, input logic [4:0] fr);
        bus.ex_valid  = v;
        bus.ex_result = r;
        bus.ex_rd     = rd;
        bus.ex_we     = we;
        bus.wb_ready  = wr;
        bus.flush     = fl;
        bus.fwd_rs    = fr;
    endtask

    // Head payload is only defined while valid, except under reset where it must read zero.
    task automatic expect_out(input string nm, input logic er, input logic wv, input logic [31:0] wres,
                              input logic [4:0] wrd, input logic wwe, input logic hit,
                              input logic [31:0] fd, input logic [1:0] oc);
        logic bad;
        logic cmp_pl;
        cmp_pl = wv | rst;
        bad = (bus.ex_ready !== er) || (bus.wb_valid !== wv) || (bus.fwd_hit !== hit) ||
              (bus.fwd_data !== fd) || (bus.occ !== oc);
        if (cmp_pl)
            bad = bad || (bus.wb_result !== wres) || (bus.wb_rd !== wrd) || (bus.wb_we !== wwe);
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got rdy=%b val=%b res=%h rd=%0d we=%b hit=%b fd=%h occ=%0d, want rdy=%b val=%b res=%h rd=%0d we=%b hit=%b fd=%h occ=%0d",
                     nm, bus.ex_ready, bus.wb_valid, bus.wb_result, bus.wb_rd, bus.wb_we, bus.fwd_hit,
                     bus.fwd_data, bus.occ, er, wv, wres, wrd, wwe, hit, fd, oc);
        end
    endtask

    initial begin
        //   name         v  result        rd  we wr fl fr   | rdy val res           rd  we hit fd     occ
        add("pt_push",    1, 32'h0000_00F0, 5, 1, 1, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("pt_out",     0, 32'h0,         0, 0, 1, 0, 5,    1, 1, 32'h0000_00F0, 5,  1, 1, 32'hF0, 1);
        add("pt_empty",   0, 32'h0,         0, 0, 1, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("bp_pushA",   1, 32'h11,        3, 1, 0, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("bp_pushB",   1, 32'h22,        4, 1, 0, 0, 4,    1, 1, 32'h11,        3,  1, 0, 32'h0,  1);
        add("bp_full",    1, 32'h33,        6, 1, 0, 0, 4,    0, 1, 32'h11,        3,  1, 1, 32'h22, 2);
        add("bp_popA",    0, 32'h0,         0, 0, 1, 0, 6,    0, 1, 32'h11,        3,  1, 0, 32'h0,  2);
        add("bp_popB",    0, 32'h0,         0, 0, 1, 0, 3,    1, 1, 32'h22,        4,  1, 0, 32'h0,  1);
        add("bp_empty",   0, 32'h0,         0, 0, 1, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("x0_push",    1, 32'hDEAD_BEEF, 0, 1, 0, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("x0_hold",    0, 32'h0,         0, 0, 0, 0, 0,    1, 1, 32'hDEAD_BEEF, 0,  0, 0, 32'h0,  1);
        add("x0_pop",     0, 32'h0,         0, 0, 1, 0, 0,    1, 1, 32'hDEAD_BEEF, 0,  0, 0, 32'h0,  1);
        add("x0_empty",   0, 32'h0,         0, 0, 1, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("fw_pushA",   1, 32'h1,         7, 1, 0, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("fw_pushB",   1, 32'h2,         7, 1, 0, 0, 7,    1, 1, 32'h1,         7,  1, 1, 32'h1,  1);
        add("fw_young",   0, 32'h0,         0, 0, 0, 0, 7,    0, 1, 32'h1,         7,  1, 1, 32'h2,  2);
        add("fw_miss",    0, 32'h0,         0, 0, 0, 0, 8,    0, 1, 32'h1,         7,  1, 0, 32'h0,  2);
        add("fl_full",    1, 32'h55,        9, 1, 1, 1, 0,    0, 1, 32'h1,         7,  1, 0, 32'h0,  2);
        add("fl_after",   0, 32'h0,         0, 0, 1, 0, 7,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("fl_push",    1, 32'h66,       10, 1, 1, 1, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("fl_dropped", 0, 32'h0,         0, 0, 1, 0, 10,   1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("nowe_push",  1, 32'h77,       11, 0, 0, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);
        add("nowe_out",   0, 32'h0,         0, 0, 1, 0, 11,   1, 1, 32'h77,       11,  0, 0, 32'h0,  1);
        add("nowe_empty", 0, 32'h0,         0, 0, 1, 0, 0,    1, 0, 32'h0,         0,  0, 0, 32'h0,  0);

        drive(0, 32'h0, 5'd0, 0, 1, 0, 5'd0);
        #2;
        expect_out("reset", 1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 2'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].ex_valid, vecs[i].ex_result, vecs[i].ex_rd, vecs[i].ex_we,
                  vecs[i].wb_ready, vecs[i].flush, vecs[i].fwd_rs);
            #1;
            expect_out(vecs[i].name, vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_res, vecs[i].e_rd,
                       vecs[i].e_we, vecs[i].e_hit, vecs[i].e_fd, vecs[i].e_occ);
            @(posedge clk); #1;
        end

        // Reset asserted between edges with one entry held must clear outputs at once.
        drive(1, 32'hAB, 5'd2, 1, 0, 0, 5'd0);
        @(posedge clk); #1;
        drive(0, 32'h0, 5'd0, 0, 0, 0, 5'd2);
        #1;
        expect_out("pre_rst", 1, 1, 32'hAB, 5'd2, 1, 1, 32'hAB, 2'd1);
        #1 rst = 1'b1;
        #1;
        expect_out("async_rst", 1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 2'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        expect_out("post_rst", 1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 2'd0);

        model_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic        v, wr, fl, we, e_hit, do_push, do_pop;
            logic [31:0] r, e_fd;
            logic [4:0]  rd, fr;
            ent_t        e;
            v  = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 63) == 0);
            we = ($urandom_range(0, 3) != 0);
            r  = $urandom;
            rd = 5'($urandom_range(0, 7));
            fr = 5'($urandom_range(0, 7));
            drive(v, r, rd, we, wr, fl, fr);
            #1;
            e_hit = 1'b0;
            e_fd  = 32'h0;
            if (fr != 5'd0)
                foreach (model_q[k])
                    if (model_q[k].we && model_q[k].rd == fr) begin
                        e_hit = 1'b1;
                        e_fd  = model_q[k].res;
                    end
            if (model_q.size() != 0)
                expect_out("rand", model_q.size() < 2, 1, model_q[0].res, model_q[0].rd, model_q[0].we,
                           e_hit, e_fd, 2'(model_q.size()));
            else
                expect_out("rand", 1, 0, 32'h0, 5'd0, 0, e_hit, e_fd, 2'd0);
            do_push = v && (model_q.size() < 2);
            do_pop  = wr && (model_q.size() != 0);
            if (fl) begin
                model_q.delete();
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    e.res = r;
                    e.rd  = rd;
                    e.we  = we && (rd != 5'd0);
                    model_q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
